// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus bundle: the instruction-memory port, the front-end
// control inputs (halt / redirect) and the decode-side valid/ready port.
interface fetch_sequencer_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              halt;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic [15:0]       fetch_count;

   // Sequencer side
   modport master (
      output mem_addr,
      input  mem_rdata,
      input  halt,
      input  redirect,
      input  redirect_addr,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output fetch_count
   );

   // Memory / decode / control side
   modport slave (
      input  mem_addr,
      output mem_rdata,
      output halt,
      output redirect,
      output redirect_addr,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  fetch_count
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives the PC onto a combinational-read
// instruction memory, captures {pc, word} into a small circular prefetch
// queue and hands instructions to decode over valid/ready. Supports
// backpressure, halt, and branch/jump redirect with queue flush.
module fetch_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic               clk,
   input  logic               reset,
   fetch_sequencer_if.master  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [15:0]       fcnt_q, fcnt_d;

   logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
   logic [DATA_W-1:0] instr_mem_q [DEPTH];

   logic pop;
   logic push;
   logic unused_ok;

   // Redirect targets are word aligned; the two low address bits are dropped.
   assign unused_ok = ^bus.redirect_addr[1:0];

   // A pop frees a slot in the same cycle, so a full queue can still accept
   // a push when decode takes the head (out_ready -> push is combinational).
   assign pop  = bus.out_valid & bus.out_ready;
   assign push = ~bus.redirect & ~bus.halt & ((count_q < DEPTH_C) | pop);

   assign bus.mem_addr    = pc_q;
   assign bus.out_valid   = (count_q != '0);
   assign bus.out_instr   = instr_mem_q[head_q];
   assign bus.out_pc      = pc_mem_q[head_q];
   assign bus.fetch_count = fcnt_q;

   // Next-state: redirect flushes and reloads the PC, otherwise push/pop.
   always_comb begin
      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      fcnt_d  = fcnt_q;
      if (bus.redirect) begin
         pc_d    = {bus.redirect_addr[ADDR_W-1:2], 2'b00};
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            tail_d = tail_q + PTR_W'(1);
            pc_d   = pc_q + ADDR_W'(4);
            fcnt_d = fcnt_q + 16'd1;
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Control registers: PC, pointers, occupancy and fetch counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         fcnt_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Queue storage: cleared on reset so the head reads zero, written at tail on push.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[tail_q]    <= pc_q;
         instr_mem_q[tail_q] <= bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// compared every cycle against a queue-of-PCs reference model.
module tb_fetch_sequencer;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image byte[i] = i, little-endian words.
   function automatic logic [31:0] word_at(input int a);
      return {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)};
   endfunction

   always_comb bus.mem_rdata = word_at(int'(bus.mem_addr));

   // Reference model: queued PCs (instruction is implied by the memory image).
   int mq[$];
   int mpc;
   int mfc;
   bit just_reset;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_check();
      chk("mem_addr", 32'(bus.mem_addr), 32'(mpc));
      chk("fetch_count", 32'(bus.fetch_count), 32'(mfc));
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("out_pc", 32'(bus.out_pc), 32'(mq[0]));
         chk("out_instr", bus.out_instr, word_at(mq[0]));
      end else if (just_reset) begin
         chk("reset_out_pc", 32'(bus.out_pc), 32'd0);
         chk("reset_out_instr", bus.out_instr, 32'd0);
      end
   endtask

   task automatic model_update(input logic r, input logic rd, input logic [4:0] ra,
                               input logic h, input logic rdy);
      bit pop;
      bit push;
      pop = (mq.size() != 0) && rdy;
      if (r) begin
         mq.delete();
         mpc = 0;
         mfc = 0;
         just_reset = 1'b1;
      end else begin
         just_reset = 1'b0;
         if (rd) begin
            mq.delete();
            mpc = int'(ra) & ~3;
         end else begin
            push = !h && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
               mq.push_back(mpc);
               mpc = (mpc + 4) % (1 << ADDR_W);
               mfc = (mfc + 1) % 65536;
            end
         end
      end
   endtask

   // One clock: drive inputs, check registered outputs at negedge, advance model.
   task automatic step(input logic r, input logic rd, input logic [4:0] ra,
                       input logic h, input logic rdy);
      reset             = r;
      bus.redirect      = rd;
      bus.redirect_addr = ra;
      bus.halt          = h;
      bus.out_ready     = rdy;
      @(negedge clk);
      model_check();
      model_update(r, rd, ra, h, rdy);
      @(posedge clk);
      #1;
   endtask

   logic [4:0]  saved_addr;
   logic [15:0] saved_fc;

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_addr = '0;
      bus.halt = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mq.delete();
      mpc = 0;
      mfc = 0;
      just_reset = 1'b1;

      // Streaming with out_ready held: pc 0,4,8,12 back-to-back.
      repeat (4) step(0, 0, 5'd0, 0, 1);
      chk("plan1_pc", 32'(bus.out_pc), 32'h0C);
      chk("plan1_instr", bus.out_instr, 32'h0F0E0D0C);
      chk("plan1_fc", 32'(bus.fetch_count), 32'd4);
      step(0, 0, 5'd0, 0, 1);

      // Backpressure from reset: queue fills, PC parks at 8.
      step(1, 0, 5'd0, 0, 0);
      repeat (6) step(0, 0, 5'd0, 0, 0);
      chk("fill_mem_addr", 32'(bus.mem_addr), 32'h08);
      chk("fill_fc", 32'(bus.fetch_count), 32'd2);
      chk("fill_out_pc", 32'(bus.out_pc), 32'h00);
      repeat (4) step(0, 0, 5'd0, 0, 1);

      // Redirect to 0x13 with a full queue.
      repeat (3) step(0, 0, 5'd0, 0, 0);
      step(0, 1, 5'h13, 0, 0);
      chk("redir_valid", 32'(bus.out_valid), 32'd0);
      chk("redir_mem_addr", 32'(bus.mem_addr), 32'h10);
      step(0, 0, 5'd0, 0, 1);
      chk("redir_out_pc", 32'(bus.out_pc), 32'h10);
      chk("redir_instr", bus.out_instr, 32'h13121110);

      // PC wrap-around from 0x18.
      step(0, 1, 5'h18, 0, 1);
      step(0, 0, 5'd0, 0, 1);
      step(0, 0, 5'd0, 0, 1);
      chk("wrap_pc_1c", 32'(bus.out_pc), 32'h1C);
      chk("wrap_instr_1c", bus.out_instr, 32'h1F1E1D1C);
      repeat (4) step(0, 0, 5'd0, 0, 1);

      // Halt drains the queue without fetching; redirect honoured while halted.
      repeat (3) step(0, 0, 5'd0, 0, 0);
      saved_addr = bus.mem_addr;
      saved_fc   = bus.fetch_count;
      repeat (3) step(0, 0, 5'd0, 1, 1);
      chk("halt_valid", 32'(bus.out_valid), 32'd0);
      chk("halt_mem_addr", 32'(bus.mem_addr), 32'(saved_addr));
      chk("halt_fc", 32'(bus.fetch_count), 32'(saved_fc));
      step(0, 1, 5'h08, 1, 1);
      step(0, 0, 5'd0, 0, 1);
      chk("halt_redir_pc", 32'(bus.out_pc), 32'h08);
      repeat (3) step(0, 0, 5'd0, 0, 1);

      // Reset wins over redirect with a full queue.
      repeat (3) step(0, 0, 5'd0, 0, 0);
      step(1, 1, 5'h13, 0, 0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_out_pc", 32'(bus.out_pc), 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      chk("rst_fc", 32'(bus.fetch_count), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 7) == 0),
              5'($urandom),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 1) == 1));
      end
      step(0, 0, 5'd0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the MIPS front end. It drives the byte address of the combinational-read instruction memory, which returns a 32-bit little-endian word per address. It captures each returned word with its PC into a small prefetch queue and presents instructions to decode over a valid/ready handshake. It replaces the free-running PC register and +4 adder with a sequenced PC that supports stall (backpressure), halt and branch/jump redirect with queue flush.

## Interface
Parameters:
- ADDR_W, 5, byte-address width of instruction memory; PC arithmetic is modulo 2^ADDR_W.
- DATA_W, 32, instruction width.
- DEPTH, 2, prefetch queue entries; legal values are 2 and 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_addr  output  ADDR_W  fetch address to instruction memory (current PC).
- mem_rdata  input  DATA_W  word at mem_addr, valid in the same cycle.
- halt  input  1  when 1, no new fetches; queue still drains.
- redirect  input  1  branch/jump taken; flush and reload PC.
- redirect_addr  input  ADDR_W  new PC; bits [1:0] ignored and forced to 0.
- out_valid  output  1  queue head holds an instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  DATA_W  head instruction.
- out_pc  output  ADDR_W  PC of head instruction.
- fetch_count  output  16  number of words pushed since reset; wraps at 2^16.

## Operation
- State:
  - pc register.
  - Circular queue of DEPTH entries {pc, instr}.
  - Head and tail pointers.
  - count, ranging 0..DEPTH.
  - fetch_count.
- mem_addr = pc (combinational from register).
- Definitions:
  - pop = out_valid & out_ready.
  - push = !redirect & !halt & (count < DEPTH | pop).
- Priority each cycle:
  1. reset:
     - pc = 0.
     - count = 0, pointers = 0.
     - All entries = 0.
     - fetch_count = 0.
  2. redirect:
     - pc = {redirect_addr[ADDR_W-1:2], 2'b00}.
     - count = 0 and pointers reset, which flushes the queue.
     - No push.
     - A pop handshake in this cycle still counts as a transfer to decode.
  3. Otherwise:
     - On push: write {pc, mem_rdata} at tail, advance tail, pc = pc + 4 (mod 2^ADDR_W), fetch_count + 1.
     - On pop: advance head.
     - count += push - pop. Simultaneous push and pop when full leaves count = DEPTH.
- out_valid = (count != 0). out_instr and out_pc always show the head entry, which is don't-care when out_valid = 0.
- halt only blocks push. pc holds while halted. Redirect is honoured while halted.
- PC wrap-around: pc = 2^ADDR_W - 4 increments to 0 with no flag.
- out_ready combinationally gates push when full; this is the only input-to-internal combinational path. out_valid, out_instr and out_pc depend on registers only.

## Timing
- Reset values: mem_addr = 0, out_valid = 0, out_instr = 0, out_pc = 0, fetch_count = 0.
- Fetch-to-decode latency is 1 cycle. The word fetched in cycle N appears with out_valid in cycle N+1.
- First cycle after reset deasserts: mem_addr = 0 and push. The next cycle has out_valid = 1, out_pc = 0.
- Redirect in cycle N:
  - mem_addr = redirect target in N+1.
  - out_valid = 0 in N+1.
  - First redirected instruction valid in N+2.
- With out_ready held 1 and no halt/redirect, throughput is one instruction per cycle.
- With out_ready = 0, the queue fills after DEPTH pushes; pc then holds and mem_addr is stable.
- Reset mid-operation discards queue contents on the next edge regardless of redirect or halt.

## Test plan
Bench memory model: byte[i] = i, so word(a) = {a+3, a+2, a+1, a}.
- Reset, then out_ready = 1 for 4 cycles -> out_pc = 0, 4, 8, 12 on consecutive cycles; out_instr = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; fetch_count = 4.
- out_ready = 0 from reset for 6 cycles -> count reaches DEPTH = 2; mem_addr holds 8; fetch_count = 2; out_pc stays 0. Release out_ready -> outputs pc 0, 4, 8 back-to-back with no bubble.
- redirect = 1, redirect_addr = 0x13 with queue full -> next cycle out_valid = 0 and mem_addr = 0x10; the cycle after, out_pc = 0x10 and out_instr = 0x13121110.
- Run from pc 0x18 with out_ready = 1 -> out_pc sequence 0x18, 0x1C, 0x00, 0x04; the instruction at 0x1C = 0x1F1E1D1C.
- halt = 1 for 3 cycles with 2 entries queued and out_ready = 1 -> the two entries drain, then out_valid = 0; mem_addr is constant and fetch_count is unchanged. redirect during halt to 0x08 -> after halt drops, out_pc = 0x08.
- reset asserted for 1 cycle while the queue is full and redirect = 1 -> next cycle all outputs are at their reset values and mem_addr = 0.
